// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the round-robin 2:1 mux arbiter.
package mux_arb_pkg;

   // Requester identity; also used for the grant and the output source tag.
   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_t;

   localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/data_mux2.sv
// Combinational 2:1 payload select: y = sel ? b : a.
module data_mux2 #(
   parameter int DATA_W = 8
) (
   input  logic              sel,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter between two valid/ready requesters feeding a shared
// 2:1 mux and a one-entry registered output stage.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid_i,
   input  logic [DATA_W-1:0] a_data_i,
   output logic              a_ready_o,
   input  logic              b_valid_i,
   input  logic [DATA_W-1:0] b_data_i,
   output logic              b_ready_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_src_o,
   input  logic              out_ready_i
);

   // Output occupancy states.
   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   logic              state_q;
   logic [DATA_W-1:0] data_q;
   src_t              src_q;
   src_t              last_grant_q;

   src_t              grant;
   logic              grant_vld;
   logic              can_accept;
   logic              accept;
   logic [DATA_W-1:0] mux_y;

   // Grant: an uncontested requester wins; on contention the one not granted last wins.
   always_comb begin
      grant_vld = a_valid_i | b_valid_i;
      grant     = SRC_A;
      if (a_valid_i && b_valid_i)
         grant = (last_grant_q == SRC_A) ? SRC_B : SRC_A;
      else if (b_valid_i)
         grant = SRC_B;
   end

   // The register may take a new item when empty or when it drains this cycle.
   // Readies are suppressed while reset is held so nothing is lost to the flush.
   assign can_accept = (state_q == ST_EMPTY) | out_ready_i;
   assign accept     = grant_vld & can_accept & ~reset;
   assign a_ready_o  = accept & (grant == SRC_A);
   assign b_ready_o  = accept & (grant == SRC_B);

   data_mux2 #(.DATA_W(DATA_W)) u_mux (
      .sel (grant),
      .a   (a_data_i),
      .b   (b_data_i),
      .y   (mux_y)
   );

   // Output register and occupancy FSM; last_grant starts at B so A wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_EMPTY;
         data_q       <= '0;
         src_q        <= SRC_A;
         last_grant_q <= SRC_B;
      end else if (accept) begin
         state_q      <= ST_FULL;
         data_q       <= mux_y;
         src_q        <= grant;
         last_grant_q <= grant;
      end else if (out_ready_i) begin
         state_q      <= ST_EMPTY;
      end
   end

   assign out_valid_o = (state_q == ST_FULL);
   assign out_data_o  = data_q;
   assign out_src_o   = src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, contention, single source,
// backpressure, streaming, mid-operation reset and idle.
module tb_mux_rr_arbiter;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              a_valid_i, b_valid_i, out_ready_i;
   logic [DATA_W-1:0] a_data_i, b_data_i;
   logic              a_ready_o, b_ready_o, out_valid_o, out_src_o;
   logic [DATA_W-1:0] out_data_o;

   int checks = 0;
   int errors = 0;

   mux_rr_arbiter #(.DATA_W(DATA_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .a_valid_i   (a_valid_i),
      .a_data_i    (a_data_i),
      .a_ready_o   (a_ready_o),
      .b_valid_i   (b_valid_i),
      .b_data_i    (b_data_i),
      .b_ready_o   (b_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_src_o   (out_src_o),
      .out_ready_i (out_ready_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_d [4];
      logic       exp_s [4];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h13; exp_d[3] = 8'h24;
      exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b0;  exp_s[3] = 1'b1;

      // Reset with A requesting: no ready may be raised
      reset = 1'b1; a_valid_i = 1'b1; a_data_i = 8'h99;
      b_valid_i = 1'b0; b_data_i = 8'h00; out_ready_i = 1'b1;
      #2;
      chk("rst_a_ready", 32'(a_ready_o), 0);
      chk("rst_b_ready", 32'(b_ready_o), 0);
      tick();
      chk("rst_valid", 32'(out_valid_o), 0);
      chk("rst_data",  32'(out_data_o), 0);
      chk("rst_src",   32'(out_src_o), 0);

      // Contention: A, B, A, B with each side advancing after acceptance
      reset = 1'b0;
      a_valid_i = 1'b1; a_data_i = 8'h11;
      b_valid_i = 1'b1; b_data_i = 8'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cont_a_ready", 32'(a_ready_o), 32'(!exp_s[i]));
         chk("cont_b_ready", 32'(b_ready_o), 32'(exp_s[i]));
         tick();
         chk("cont_valid", 32'(out_valid_o), 1);
         chk("cont_data",  32'(out_data_o), 32'(exp_d[i]));
         chk("cont_src",   32'(out_src_o), 32'(exp_s[i]));
         if (exp_s[i]) b_data_i = b_data_i + 8'h02;
         else          a_data_i = a_data_i + 8'h02;
      end

      // A alone
      b_valid_i = 1'b0; a_data_i = 8'h3C;
      #1;
      chk("solo_a_ready", 32'(a_ready_o), 1);
      chk("solo_b_ready", 32'(b_ready_o), 0);
      tick();
      chk("solo_valid", 32'(out_valid_o), 1);
      chk("solo_data",  32'(out_data_o), 'h3C);
      chk("solo_src",   32'(out_src_o), 0);

      // Backpressure: B's 0xA5 is held while A waits
      a_valid_i = 1'b0; b_valid_i = 1'b1; b_data_i = 8'hA5;
      #1;
      chk("bp_b_ready", 32'(b_ready_o), 1);
      tick();
      chk("bp_b_data", 32'(out_data_o), 'hA5);
      b_valid_i = 1'b0; a_valid_i = 1'b1; a_data_i = 8'h5A; out_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_a_ready", 32'(a_ready_o), 0);
         tick();
         chk("bp_hold_valid", 32'(out_valid_o), 1);
         chk("bp_hold_data",  32'(out_data_o), 'hA5);
         chk("bp_hold_src",   32'(out_src_o), 1);
      end
      out_ready_i = 1'b1;
      #1;
      chk("bp_release_a_ready", 32'(a_ready_o), 1);
      tick();
      chk("bp_release_data", 32'(out_data_o), 'h5A);
      chk("bp_release_src",  32'(out_src_o), 0);

      // Back-to-back stream 0x01..0x08 from A
      for (int i = 1; i <= 8; i++) begin
         a_data_i = 8'(i);
         #1;
         chk("b2b_a_ready", 32'(a_ready_o), 1);
         tick();
         chk("b2b_valid", 32'(out_valid_o), 1);
         chk("b2b_data",  32'(out_data_o), 32'(i));
      end

      // Fill with 0x77 and stall, then reset mid-operation
      a_data_i = 8'h77;
      tick();
      a_valid_i = 1'b0; out_ready_i = 1'b0;
      tick();
      chk("mid_full_valid", 32'(out_valid_o), 1);
      chk("mid_full_data",  32'(out_data_o), 'h77);
      reset = 1'b1; a_valid_i = 1'b1; a_data_i = 8'h31;
      b_valid_i = 1'b1; b_data_i = 8'h42; out_ready_i = 1'b1;
      #1;
      chk("mid_rst_a_ready", 32'(a_ready_o), 0);
      chk("mid_rst_b_ready", 32'(b_ready_o), 0);
      tick();
      chk("mid_rst_valid", 32'(out_valid_o), 0);
      chk("mid_rst_data",  32'(out_data_o), 0);
      reset = 1'b0;
      #1;
      chk("post_rst_a_ready", 32'(a_ready_o), 1);
      chk("post_rst_b_ready", 32'(b_ready_o), 0);
      tick();
      chk("post_rst_data", 32'(out_data_o), 'h31);
      chk("post_rst_src",  32'(out_src_o), 0);

      // Idle: nothing valid, last grant (A) must be preserved
      a_valid_i = 1'b0; b_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_valid",   32'(out_valid_o), 0);
         chk("idle_a_ready", 32'(a_ready_o), 0);
         chk("idle_b_ready", 32'(b_ready_o), 0);
      end
      a_valid_i = 1'b1; b_valid_i = 1'b1;
      #1;
      chk("idle_next_a_ready", 32'(a_ready_o), 0);
      chk("idle_next_b_ready", 32'(b_ready_o), 1);
      tick();
      chk("idle_next_data", 32'(out_data_o), 'h42);
      chk("idle_next_src",  32'(out_src_o), 1);
      a_valid_i = 1'b0; b_valid_i = 1'b0;
      tick();
      chk("drain_valid", 32'(out_valid_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
